// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory bus between IFU and LSU
//
// Purpose:
//    Accepts one request at a time from the instruction fetch unit (read-only)
//    or the load/store unit (read/write), drives it on a single-ported memory
//    bus, waits for the bus response and returns it to the requester that
//    issued it. A hung transaction is aborted with an error response after
//    TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports:
//    clk, rst          clock (rising edge), asynchronous active-high reset
//    ifu_req_*         IFU read request handshake and address
//    ifu_resp_*        IFU one-cycle response pulse, read data, error
//    lsu_req_*         LSU request handshake, address, wen, wdata, wmask
//    lsu_resp_*        LSU one-cycle response pulse, read data (0 on writes), error
//    mem_req_*         bus request handshake with latched addr/wen/wdata/wmask
//    mem_resp_*        bus response valid, read data, error

module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     ifu_addr,
   output logic                      ifu_resp_valid,
   output logic [DATA_WIDTH-1:0]     ifu_rdata,
   output logic                      ifu_resp_err,

   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     lsu_addr,
   input  logic                      lsu_wen,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
   output logic                      lsu_resp_valid,
   output logic [DATA_WIDTH-1:0]     lsu_rdata,
   output logic                      lsu_resp_err,

   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic                      mem_wen,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wmask,
   input  logic                      mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_resp_err
);

   // A zero-width timer is not legal, so keep one bit when the timeout is off.
   localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
      (TIMEOUT_CYCLES > 0) ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   logic [1:0]             state;
   logic                   owner;
   logic                   rr_last;
   logic [TIMER_WIDTH-1:0] timer;

   logic                   grant_ifu;
   logic                   grant_lsu;
   logic                   timed_out;
   logic                   resp_fire;
   logic                   resp_err;
   logic [DATA_WIDTH-1:0]  resp_data;

   // On a tie the side that did not win last time is granted.
   always_comb begin
      grant_ifu = ifu_req_valid & (~lsu_req_valid | (rr_last == OWN_LSU));
      grant_lsu = lsu_req_valid & (~ifu_req_valid | (rr_last == OWN_IFU));
   end

   // Ready is qualified with rst so that every output reads 0 while reset is
   // held, even if a requester keeps its valid asserted.
   assign ifu_req_ready = (state == S_IDLE) & ~rst & grant_ifu;
   assign lsu_req_ready = (state == S_IDLE) & ~rst & grant_lsu;
   assign mem_req_valid = (state == S_REQ);

   assign timed_out = (TIMEOUT_CYCLES > 0) && (state != S_IDLE) && (timer == TIMER_LAST);

   // A real bus response in RESP takes precedence over a timeout in the same
   // cycle; in REQ the timeout wins over a late request handshake, and any
   // response that then trickles in lands in IDLE where it is ignored.
   always_comb begin
      resp_fire = 1'b0;
      resp_err  = 1'b0;
      resp_data = '0;
      if ((state == S_RESP) && mem_resp_valid) begin
         resp_fire = 1'b1;
         resp_err  = mem_resp_err;
         resp_data = mem_wen ? '0 : mem_rdata;
      end else if (timed_out) begin
         resp_fire = 1'b1;
         resp_err  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         owner          <= OWN_IFU;
         rr_last        <= OWN_LSU;
         timer          <= '0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_resp_err   <= 1'b0;
         ifu_rdata      <= '0;
         lsu_resp_valid <= 1'b0;
         lsu_resp_err   <= 1'b0;
         lsu_rdata      <= '0;
      end else begin
         // Response valid and error are single-cycle pulses; read data holds.
         ifu_resp_valid <= 1'b0;
         ifu_resp_err   <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_resp_err   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_ifu | grant_lsu) begin
                  owner     <= grant_lsu;
                  rr_last   <= grant_lsu;
                  mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
                  mem_wen   <= grant_lsu & lsu_wen;
                  mem_wdata <= grant_lsu ? lsu_wdata : '0;
                  mem_wmask <= grant_lsu ? lsu_wmask : '0;
                  timer     <= '0;
                  state     <= S_REQ;
               end
            end

            S_REQ, S_RESP: begin
               if (resp_fire) begin
                  if (owner == OWN_LSU) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_resp_err   <= resp_err;
                     lsu_rdata      <= resp_data;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_resp_err   <= resp_err;
                     ifu_rdata      <= resp_data;
                  end
                  state <= S_IDLE;
               end else if ((state == S_REQ) && mem_req_ready) begin
                  timer <= '0;
                  state <= S_RESP;
               end else if (timer != TIMER_MAX) begin
                  timer <= timer + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        ifu_resp_err;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        lsu_resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        mem_resp_err;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .ifu_resp_err   (ifu_resp_err),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .lsu_resp_err   (lsu_resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata),
      .mem_resp_err   (mem_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
      chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
      chk("rst_ifu_rdata", ifu_rdata, 0);

      // Single IFU read
      @(negedge clk); rst = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; #1;
      chk("t1_ifu_ready", ifu_req_ready, 1);
      chk("t1_lsu_ready", lsu_req_ready, 0);
      @(negedge clk); ifu_req_valid = 1'b0; ifu_addr = '0; mem_req_ready = 1'b1; #1;
      chk("t1_mem_req_valid", mem_req_valid, 1);
      chk("t1_mem_addr", mem_addr, 32'h8000_0000);
      chk("t1_mem_wen", mem_wen, 0);
      chk("t1_ifu_ready_req", ifu_req_ready, 0);
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073; #1;
      chk("t1_mem_req_valid_resp", mem_req_valid, 0);
      chk("t1_no_early_resp", ifu_resp_valid, 0);
      @(negedge clk); mem_resp_valid = 1'b0; mem_rdata = '0; #1;
      chk("t1_ifu_resp_valid", ifu_resp_valid, 1);
      chk("t1_ifu_rdata", ifu_rdata, 32'h0010_0073);
      chk("t1_ifu_resp_err", ifu_resp_err, 0);
      chk("t1_lsu_resp_valid", lsu_resp_valid, 0);
      @(negedge clk); #1;
      chk("t1_pulse_one_cycle", ifu_resp_valid, 0);

      // Asynchronous reset in the middle of an LSU write's RESP phase
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010;
      lsu_wdata = 32'h1111_2222; lsu_wmask = 4'hF; #1;
      chk("rst_mid_lsu_ready", lsu_req_ready, 1);
      @(negedge clk); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      chk("rst_mid_mem_wdata", mem_wdata, 32'h1111_2222);
      @(negedge clk); mem_req_ready = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_2000; #1;
      chk("rst_mid_in_resp", mem_req_valid, 0);
      #2; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_DEAD; #1;
      chk("rst_async_mem_addr", mem_addr, 0);
      chk("rst_async_mem_wen", mem_wen, 0);
      chk("rst_async_mem_wdata", mem_wdata, 0);
      chk("rst_async_mem_wmask", mem_wmask, 0);
      chk("rst_async_ready", {ifu_req_ready, lsu_req_ready}, 0);
      chk("rst_async_ifu_rdata", ifu_rdata, 0);
      chk("rst_async_lsu_resp", lsu_resp_valid, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_rel_no_lsu_resp", lsu_resp_valid, 0);

      // Round robin with both sides requesting every cycle
      for (int i = 0; i < 4; i++) begin
         logic own_lsu;
         own_lsu = (i % 2) == 1;
         #1;
         chk("rr_ifu_ready", ifu_req_ready, !own_lsu);
         chk("rr_lsu_ready", lsu_req_ready, own_lsu);
         @(negedge clk); mem_req_ready = 1'b1; mem_resp_valid = 1'b0; #1;
         chk("rr_mem_req_valid", mem_req_valid, 1);
         chk("rr_mem_addr", mem_addr, own_lsu ? 32'h0000_2000 : 32'h0000_1000);
         chk("rr_ready_off_req", {ifu_req_ready, lsu_req_ready}, 0);
         @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_0000 + i; #1;
         chk("rr_ready_off_resp", {ifu_req_ready, lsu_req_ready}, 0);
         @(negedge clk); mem_resp_valid = 1'b0; #1;
         chk("rr_ifu_resp_valid", ifu_resp_valid, !own_lsu);
         chk("rr_lsu_resp_valid", lsu_resp_valid, own_lsu);
         chk("rr_rdata", own_lsu ? lsu_rdata : ifu_rdata, 32'hA5A5_0000 + i);
      end

      // LSU write under bus backpressure, requester inputs changing meanwhile
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_wen = 1'b1;
      lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; #1;
      chk("bp_lsu_ready", lsu_req_ready, 1);
      @(negedge clk); lsu_addr = '0; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3; lsu_wen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_mem_req_valid", mem_req_valid, 1);
         chk("bp_mem_addr", mem_addr, 32'h8000_0100);
         chk("bp_mem_wen", mem_wen, 1);
         chk("bp_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("bp_mem_wmask", mem_wmask, 4'hF);
         chk("bp_lsu_ready_off", lsu_req_ready, 0);
         @(negedge clk); lsu_addr = lsu_addr + 32'd4;
      end
      mem_req_ready = 1'b1; lsu_req_valid = 1'b0; #1;
      chk("bp_hs_mem_addr", mem_addr, 32'h8000_0100);
      chk("bp_hs_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
      @(negedge clk); mem_resp_valid = 1'b0; #1;
      chk("bp_lsu_resp_valid", lsu_resp_valid, 1);
      chk("bp_lsu_rdata_write", lsu_rdata, 0);
      chk("bp_lsu_resp_err", lsu_resp_err, 0);
      chk("bp_ifu_resp_valid", ifu_resp_valid, 0);

      // Bus error on an LSU read, then a clean back-to-back read
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200; #1;
      chk("be_lsu_ready_b2b", lsu_req_ready, 1);
      @(negedge clk); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
      mem_rdata = 32'h55AA_55AA; mem_resp_err = 1'b1; #1;
      @(negedge clk); mem_resp_valid = 1'b0; mem_resp_err = 1'b0; #1;
      chk("be_lsu_resp_valid", lsu_resp_valid, 1);
      chk("be_lsu_resp_err", lsu_resp_err, 1);
      chk("be_lsu_rdata", lsu_rdata, 32'h55AA_55AA);
      chk("be_ifu_resp_valid", ifu_resp_valid, 0);
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0204;
      @(negedge clk); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      chk("be_err_pulse_only", lsu_resp_err, 0);
      chk("be_next_mem_addr", mem_addr, 32'h8000_0204);
      @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0001; #1;
      @(negedge clk); mem_resp_valid = 1'b0; #1;
      chk("be_next_resp_valid", lsu_resp_valid, 1);
      chk("be_next_resp_err", lsu_resp_err, 0);
      chk("be_next_rdata", lsu_rdata, 32'h0000_0001);

      // Timeout on an IFU read that the bus never accepts
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300; #1;
      chk("to_ifu_ready", ifu_req_ready, 1);
      @(negedge clk); ifu_req_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("to_mem_req_valid", mem_req_valid, 1);
         chk("to_no_early_resp", ifu_resp_valid, 0);
         @(negedge clk);
      end
      #1;
      chk("to_ifu_resp_valid", ifu_resp_valid, 1);
      chk("to_ifu_resp_err", ifu_resp_err, 1);
      chk("to_ifu_rdata", ifu_rdata, 0);
      chk("to_mem_req_valid_drop", mem_req_valid, 0);
      @(negedge clk); mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
      @(negedge clk); mem_resp_valid = 1'b0; #1;
      chk("to_late_ifu_resp", ifu_resp_valid, 0);
      chk("to_late_lsu_resp", lsu_resp_valid, 0);
      chk("to_late_ifu_rdata", ifu_rdata, 0);
      chk("to_late_mem_req_valid", mem_req_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
